// File: rtl/scr1_tb_trc_pkg.sv
// Shared types and constants for the instruction tracer.
// Holds the trace record layout, the "valid fetch" response code and the
// channel-index width used by the tracer top and its FIFO.
package scr1_tb_trc_pkg;

   localparam logic [1:0] SCR1_TRC_RESP_OK = 2'b01;
   localparam int         SCR1_TRC_CH_W    = 3;

   typedef struct packed {
      logic [31:0]              ts;
      logic [31:0]              pc;
      logic [31:0]              instr;
      logic [SCR1_TRC_CH_W-1:0] ch;
      logic                     multi;
   } scr1_tb_trc_rec_s;

endpackage : scr1_tb_trc_pkg

// File: rtl/scr1_tb_trc_fifo.sv
// Trace record FIFO.
// DEPTH is a power of two, so the read and write pointers wrap modulo DEPTH
// through plain binary overflow. The level counter runs 0..DEPTH and supplies
// full/empty. A push into a full FIFO is accepted only when a pop happens in
// the same cycle. A pop only happens when the FIFO is not empty. The head is
// read straight from storage, so a record pushed into an empty FIFO shows up
// one cycle later.
module scr1_tb_trc_fifo
   import scr1_tb_trc_pkg::*;
#(
   parameter int  DEPTH = 16,
   parameter type rec_t = scr1_tb_trc_rec_s
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  rec_t                     push_rec,
   input  logic                     pop,
   output rec_t                     head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   rec_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];
   assign level   = cnt;

   // Record storage: written on every accepted push, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_rec;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule : scr1_tb_trc_fifo

// File: rtl/scr1_tb_instr_tracer.sv
// Instruction tracer for the SCR1 testbench.
// Matches every valid imem fetch against CH_NUM mask/value channels. Any hit
// pushes one record {ts, pc, instr, ch, multi} into a trace FIFO. Per-channel
// hit counters and a dropped-record counter both saturate.
// Optional: define SCR1_TB_TRC_DISPLAY_EN to print each accepted push and each
// drop. The default build, with the macro undefined, prints nothing.
module scr1_tb_instr_tracer
   import scr1_tb_trc_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                imem_resp,
   input  logic [31:0]               imem_rdata,
   input  logic [31:0]               pc,
   input  logic [CH_NUM-1:0]         ch_en,
   input  logic [CH_NUM*32-1:0]      ch_mask,
   input  logic [CH_NUM*32-1:0]      ch_value,
   input  logic                      cnt_clr,
   output logic                      trc_vld,
   input  logic                      trc_rdy,
   output scr1_tb_trc_rec_s          trc_rec,
   output logic [CH_NUM*CNT_W-1:0]   hit_cnt,
   output logic [CNT_W-1:0]          ovf_cnt,
   output logic [$clog2(DEPTH):0]    level
);

   logic [CH_NUM-1:0]        hit;
   logic                     hit_any;
   logic                     hit_multi;
   logic [SCR1_TRC_CH_W-1:0] hit_ch;
   logic [31:0]              ts_q;
   logic [CNT_W-1:0]         hit_cnt_q [CH_NUM];
   logic [CNT_W-1:0]         ovf_q;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     pop;
   logic                     drop;
   scr1_tb_trc_rec_s         push_rec;

   // Per-channel match on the current fetch
   always_comb begin
      hit = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         hit[i] = (imem_resp == SCR1_TRC_RESP_OK) && ch_en[i] &&
                  ((imem_rdata & ch_mask[i*32 +: 32]) ==
                   (ch_value[i*32 +: 32] & ch_mask[i*32 +: 32]));
      end
   end

   // Lowest hitting channel wins; multi flags more than one hit
   always_comb begin
      hit_ch = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (hit[i]) hit_ch = SCR1_TRC_CH_W'(i);
      end
      hit_any   = |hit;
      hit_multi = |(hit & (hit - CH_NUM'(1)));
   end

   assign push_rec = '{ts: ts_q, pc: pc, instr: imem_rdata, ch: hit_ch, multi: hit_multi};

   // trc_vld is only high when the FIFO holds a record. On an empty-FIFO push,
   // trc_rdy therefore cannot pop anything, so a record never falls through.
   assign trc_vld = !fifo_empty;
   assign pop     = trc_vld && trc_rdy;
   assign drop    = hit_any && fifo_full && !pop;

   scr1_tb_trc_fifo #(
      .DEPTH (DEPTH),
      .rec_t (scr1_tb_trc_rec_s)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (hit_any),
      .push_rec (push_rec),
      .pop      (pop),
      .head     (trc_rec),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (level)
   );

   // Free-running timestamp; cnt_clr does not touch it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_q <= '0;
      else        ts_q <= ts_q + 32'd1;
   end

   // Saturating per-channel hit counters; clear beats increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH_NUM; i++) hit_cnt_q[i] <= '0;
      end else if (cnt_clr) begin
         for (int i = 0; i < CH_NUM; i++) hit_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (hit[i] && (hit_cnt_q[i] != {CNT_W{1'b1}}))
               hit_cnt_q[i] <= hit_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Saturating count of records dropped on a full FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 ovf_q <= '0;
      else if (cnt_clr)                           ovf_q <= '0;
      else if (drop && (ovf_q != {CNT_W{1'b1}}))  ovf_q <= ovf_q + CNT_W'(1);
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_hit_cnt
      assign hit_cnt[g*CNT_W +: CNT_W] = hit_cnt_q[g];
   end
   assign ovf_cnt = ovf_q;

`ifdef SCR1_TB_TRC_DISPLAY_EN
   // Simulation log of accepted pushes and drops
   always @(posedge clk) begin
      if (rst_n && hit_any) begin
         if (!fifo_full || pop)
            $display("TRC ch=%0d pc=%h instr=%h ts=%0d", hit_ch, pc, imem_rdata, ts_q);
         else
            $display("TRC OVF");
      end
   end
`endif

endmodule : scr1_tb_instr_tracer

// File: tb/tb_scr1_tb_instr_tracer.sv
// Self-checking bench for scr1_tb_instr_tracer (CH_NUM=4, DEPTH=4, CNT_W=4).
// A negedge reference model predicts level, counters and trace records. Each
// record is pushed to exp_q when the fetch is driven and compared on pop.
module tb_scr1_tb_instr_tracer;
   import scr1_tb_trc_pkg::*;

   localparam int CH_NUM = 4;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 4;
   localparam int LVL_W  = $clog2(DEPTH) + 1;
   localparam int REC_W  = $bits(scr1_tb_trc_rec_s);

   logic                    clk;
   logic                    rst_n;
   logic [1:0]              imem_resp;
   logic [31:0]             imem_rdata;
   logic [31:0]             pc;
   logic [CH_NUM-1:0]       ch_en;
   logic [CH_NUM*32-1:0]    ch_mask;
   logic [CH_NUM*32-1:0]    ch_value;
   logic                    cnt_clr;
   logic                    trc_vld;
   logic                    trc_rdy;
   scr1_tb_trc_rec_s        trc_rec;
   logic [CH_NUM*CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0]        ovf_cnt;
   logic [LVL_W-1:0]        level;

   scr1_tb_instr_tracer #(.CH_NUM(CH_NUM), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .pc(pc), .ch_en(ch_en), .ch_mask(ch_mask), .ch_value(ch_value),
      .cnt_clr(cnt_clr), .trc_vld(trc_vld), .trc_rdy(trc_rdy), .trc_rec(trc_rec),
      .hit_cnt(hit_cnt), .ovf_cnt(ovf_cnt), .level(level)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // reference model state
   int               m_level;
   logic [CNT_W-1:0] m_hit [CH_NUM];
   logic [CNT_W-1:0] m_ovf;
   logic [31:0]      m_ts;
   logic [REC_W-1:0] exp_q[$];

   function automatic logic [CH_NUM*CNT_W-1:0] m_hit_flat();
      logic [CH_NUM*CNT_W-1:0] f;
      for (int i = 0; i < CH_NUM; i++) f[i*CNT_W +: CNT_W] = m_hit[i];
      return f;
   endfunction

   // scoreboard: check state, pop/compare head, then model this cycle's inputs
   initial begin : monitor
      logic [CH_NUM-1:0] h;
      int               nh;
      int               first;
      logic             pop_m;
      logic             acc;
      logic [31:0]      msk;
      logic [31:0]      val;
      logic [REC_W-1:0] rec;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            m_level = 0;
            m_ovf   = '0;
            m_ts    = '0;
            for (int i = 0; i < CH_NUM; i++) m_hit[i] = '0;
         end else begin
            check("level", level, m_level);
            check("vld", trc_vld, m_level != 0);
            check("ovf", ovf_cnt, m_ovf);
            check("hit_cnt", hit_cnt, m_hit_flat());
            pop_m = (m_level != 0) && trc_rdy;
            if (pop_m) begin
               check("rec_avail", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) check("rec", trc_rec, exp_q.pop_front());
            end
            h = '0; nh = 0; first = 0;
            for (int i = CH_NUM - 1; i >= 0; i--) begin
               msk = ch_mask[i*32 +: 32];
               val = ch_value[i*32 +: 32];
               if (imem_resp == 2'b01 && ch_en[i] && ((imem_rdata ^ val) & msk) == 32'h0) begin
                  h[i] = 1'b1; nh++; first = i;
               end
            end
            acc = 1'b0;
            if (nh > 0 && (m_level < DEPTH || pop_m)) begin
               rec = {m_ts, pc, imem_rdata, 3'(first), (nh > 1)};
               exp_q.push_back(rec);
               acc = 1'b1;
            end
            m_level = m_level + int'(acc) - int'(pop_m);
            if (cnt_clr) begin
               for (int i = 0; i < CH_NUM; i++) m_hit[i] = '0;
               m_ovf = '0;
            end else begin
               for (int i = 0; i < CH_NUM; i++)
                  if (h[i] && m_hit[i] != {CNT_W{1'b1}}) m_hit[i] = m_hit[i] + 1'b1;
               if (nh > 0 && !acc && m_ovf != {CNT_W{1'b1}}) m_ovf = m_ovf + 1'b1;
            end
            m_ts = m_ts + 32'd1;
         end
      end
   end

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic fetch(input logic [1:0] r, input logic [31:0] d, input logic [31:0] p);
      cyc();
      imem_resp = r; imem_rdata = d; pc = p;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         cyc();
         imem_resp = 2'b00; cnt_clr = 1'b0;
      end
   endtask

   task automatic drain();
      cyc();
      imem_resp = 2'b00; cnt_clr = 1'b0; trc_rdy = 1'b1;
      for (int k = 0; k < 40 && trc_vld; k++) cyc();
      check("drain_done", trc_vld, 1'b0);
      trc_rdy = 1'b0;
   endtask

   logic [31:0] pat [6];

   initial begin
      pat = '{32'h00000033, 32'h00000013, 32'h00C58533, 32'h00A00093, 32'h0000707F, 32'h12345678};
      rst_n = 1'b0; imem_resp = 2'b00; imem_rdata = '0; pc = '0;
      ch_en = '0; ch_mask = '0; ch_value = '0; cnt_clr = 1'b0; trc_rdy = 1'b0;
      repeat (3) cyc();
      check("rst_vld", trc_vld, 1'b0);
      check("rst_level", level, 0);
      check("rst_ovf", ovf_cnt, 0);
      check("rst_hit", hit_cnt, 0);
      rst_n = 1'b1;
      ch_en = 4'b0001;
      ch_mask[31:0] = 32'h0000707F; ch_value[31:0] = 32'h00000033;

      // single-channel hit
      fetch(2'b01, 32'h00C58533, 32'h1000);
      idle(1);
      check("t1_vld", trc_vld, 1'b1);
      check("t1_level", level, 1);
      check("t1_ch", trc_rec.ch, 0);
      check("t1_multi", trc_rec.multi, 1'b0);
      check("t1_pc", trc_rec.pc, 32'h1000);
      check("t1_cnt0", hit_cnt[0 +: CNT_W], 1);
      drain();

      // two channels hit
      ch_en = 4'b0101;
      ch_mask[95:64] = 32'h0000007F; ch_value[95:64] = 32'h00000033;
      fetch(2'b01, 32'h00000033, 32'h2000);
      idle(1);
      check("t2_ch", trc_rec.ch, 0);
      check("t2_multi", trc_rec.multi, 1'b1);
      check("t2_cnt0", hit_cnt[0 +: CNT_W], 2);
      check("t2_cnt2", hit_cnt[2*CNT_W +: CNT_W], 1);
      drain();

      // non-OK responses never match
      fetch(2'b00, 32'h00000033, 32'h2100);
      fetch(2'b10, 32'h00000033, 32'h2104);
      fetch(2'b11, 32'h00000033, 32'h2108);
      idle(1);
      check("t3_level", level, 0);
      check("t3_hit", hit_cnt, 16'h0102);

      // cnt_clr wins over a same-cycle increment, FIFO untouched
      fetch(2'b01, 32'h00000033, 32'h3000);
      cnt_clr = 1'b1;
      idle(1);
      check("t4_hit", hit_cnt, 0);
      check("t4_level", level, 1);
      drain();

      // overflow: 6 hits into a 4-deep FIFO with no consumer
      ch_en = 4'b0001;
      for (int k = 0; k < 6; k++) fetch(2'b01, 32'h00000033, 32'h200 + 32'(4*k));
      idle(1);
      check("t5_level", level, DEPTH);
      check("t5_ovf", ovf_cnt, 2);
      check("t5_head", trc_rec.pc, 32'h200);

      // full FIFO with push and pop together
      fetch(2'b01, 32'h00000033, 32'h300);
      trc_rdy = 1'b1;
      cyc();
      imem_resp = 2'b00; trc_rdy = 1'b0;
      check("t6_level", level, DEPTH);
      check("t6_ovf", ovf_cnt, 2);
      check("t6_head", trc_rec.pc, 32'h204);
      drain();

      // empty FIFO push with trc_rdy high: no fall-through
      fetch(2'b01, 32'h00000033, 32'h400);
      trc_rdy = 1'b1;
      cyc();
      imem_resp = 2'b00;
      check("t7_vld", trc_vld, 1'b1);
      check("t7_level", level, 1);
      cyc();
      check("t7_level_after", level, 0);
      trc_rdy = 1'b0;

      // counter saturation
      cnt_clr = 1'b1;
      idle(1);
      for (int k = 0; k < 24; k++) fetch(2'b01, 32'h00000033, 32'h500 + 32'(4*k));
      idle(1);
      check("t8_ovf_sat", ovf_cnt, 4'hF);
      check("t8_hit_sat", hit_cnt[0 +: CNT_W], 4'hF);
      drain();

      // reset mid-drain with 3 queued records
      for (int k = 0; k < 3; k++) fetch(2'b01, 32'h00000033, 32'h600 + 32'(4*k));
      idle(1);
      check("t9_level_pre", level, 3);
      rst_n = 1'b0;
      #1;
      check("t9_vld", trc_vld, 1'b0);
      check("t9_level", level, 0);
      check("t9_ovf", ovf_cnt, 0);
      check("t9_hit", hit_cnt, 0);
      cyc();
      rst_n = 1'b1;
      idle(5);
      imem_resp = 2'b01; imem_rdata = 32'h00000033; pc = 32'h700;
      idle(1);
      check("t9_ts", trc_rec.ts, 5);
      check("t9_vld_post", trc_vld, 1'b1);
      drain();

      // random traffic across all four channels
      ch_en = 4'b1111;
      ch_mask[63:32]  = 32'h0000007F; ch_value[63:32]  = 32'h00000013;
      ch_mask[127:96] = 32'hFFFFFFFF; ch_value[127:96] = 32'h00000013;
      for (int k = 0; k < 300; k++) begin
         cyc();
         imem_resp  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         imem_rdata = pat[$urandom_range(0, 5)];
         pc         = 32'h8000 + 32'(4*k);
         trc_rdy    = ($urandom_range(0, 2) != 0);
         cnt_clr    = ($urandom_range(0, 40) == 0);
      end
      idle(1);
      drain();
      check("queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // watchdog
   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule : tb_scr1_tb_instr_tracer

// File: doc/scr1_tb_instr_tracer.md
SCR1_TB_INSTR_TRACER -- requirements
Module: scr1_tb_instr_tracer

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 4, meaning the number of independent instruction-match channels (1..8).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the trace FIFO entry count (power of two, 2..256).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of each hit counter and of the overflow counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock of the block.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-006 The block SHALL have port imem_resp, input, 2 bits, the imem response code; 2'b01 means valid fetch data.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits, the fetched instruction word.
REQ-008 The block SHALL have port pc, input, 32 bits, the PC sample associated with the fetch.
REQ-009 The block SHALL have port ch_en, input, CH_NUM bits, the per-channel enable.
REQ-010 The block SHALL have port ch_mask, input, CH_NUM*32 bits, the per-channel instruction bit mask.
REQ-011 The block SHALL have port ch_value, input, CH_NUM*32 bits, the per-channel compare value.
REQ-012 The block SHALL have port cnt_clr, input, 1 bit, a synchronous clear of all counters.
REQ-013 The block SHALL have port trc_vld, output, 1 bit, indicating that the FIFO head record is valid.
REQ-014 The block SHALL have port trc_rdy, input, 1 bit, the consumer accept signal for the head record.
REQ-015 The block SHALL have port trc_rec, output, scr1_tb_trc_rec_s, the head record {ts[31:0], pc[31:0], instr[31:0], ch[2:0], multi}.
REQ-016 The block SHALL have port hit_cnt, output, CH_NUM*CNT_W bits, the per-channel saturating hit counters.
REQ-017 The block SHALL have port ovf_cnt, output, CNT_W bits, the saturating count of dropped records.
REQ-018 The block SHALL have port level, output, $clog2(DEPTH)+1 bits, the current FIFO occupancy.

Function
REQ-019 Channel i SHALL hit when imem_resp==2'b01, ch_en[i]==1 and (imem_rdata & mask_i)==(value_i & mask_i), evaluated combinationally in the same cycle.
REQ-020 On any hit, the record SHALL carry ch equal to the lowest-index hitting channel, with multi=1 when more than one channel hits.
REQ-021 Every hitting channel SHALL increment its own counter in the cycle following the hit, saturating at 2^CNT_W-1.
REQ-022 The timestamp SHALL be a free-running 32-bit cycle counter that wraps 0xFFFFFFFF->0 and is sampled into the record at the hit cycle.
REQ-023 A hit SHALL push exactly one record per cycle, and that record SHALL become visible on trc_rec/trc_vld one cycle later when the FIFO was empty.
REQ-024 A pop SHALL occur when trc_vld&&trc_rdy, and the next record SHALL be presented in the following cycle.
REQ-025 When the FIFO is full and there is no pop, a push SHALL be dropped, the FIFO contents SHALL be unchanged, and ovf_cnt SHALL increment (saturating).
REQ-026 When the FIFO is full and a push and a pop occur in the same cycle, both SHALL be accepted with level unchanged and no overflow.
REQ-027 When the FIFO is empty and a push occurs, any trc_rdy SHALL be ignored that cycle, so no fall-through occurs.
REQ-028 cnt_clr SHALL zero hit_cnt and ovf_cnt next cycle, SHALL NOT affect the FIFO or the timestamp, and SHALL take priority over an increment in the same cycle.
REQ-029 The FIFO read/write pointers SHALL wrap modulo DEPTH, and level SHALL range 0..DEPTH.

Reset
REQ-030 On rst_n low, the block SHALL asynchronously clear the pointers, level, timestamp, hit_cnt and ovf_cnt, and drive trc_vld=0; trc_rec content SHALL be don't-care while trc_vld=0.
REQ-031 Reset asserted mid-drain SHALL discard all queued records, and the first post-reset hit SHALL have a timestamp counted from 0.

Configuration
REQ-032 When SCR1_TB_TRC_DISPLAY_EN is defined, each accepted push SHALL $display "TRC ch=<ch> pc=<hex> instr=<hex> ts=<dec>", and each drop SHALL $display "TRC OVF"; when the macro is undefined, no $display SHALL be emitted and the behaviour SHALL otherwise be identical.

Structure
REQ-033 The package scr1_tb_trc_pkg SHALL hold scr1_tb_trc_rec_s, the constant SCR1_TRC_RESP_OK=2'b01 and the channel-index width.
REQ-034 The FIFO SHALL be the sub-module scr1_tb_trc_fifo (parameters DEPTH and the record type, with push/pop/full/empty/level), and matching and counters SHALL reside in the top module.

Verification
REQ-035 The bench SHALL cover: ch0 mask 0x0000707F value 0x00000033, fetch 0x00C58533 with resp=01 -> one record ch=0, multi=0, hit_cnt[0]=1.
REQ-036 The bench SHALL cover: ch0 and ch2 both matching 0x00000033 -> ch=0, multi=1, and hit_cnt[0] and hit_cnt[2] both incremented.
REQ-037 The bench SHALL cover: DEPTH=4 with trc_rdy=0 and 6 consecutive hits -> level=4, ovf_cnt=2, and drained pcs equal to the first four.
REQ-038 The bench SHALL cover: full FIFO with simultaneous hit and trc_rdy=1 -> level stays 4, ovf_cnt unchanged, and the new record is at the tail.
REQ-039 The bench SHALL cover: matching fetch with resp=2'b00 or 2'b10 -> no push and no count.
REQ-040 The bench SHALL cover: rst_n pulsed low with 3 records queued -> trc_vld=0 and level=0 immediately, counters 0, and the next hit has ts equal to cycles since deassertion.
